// File: rtl/operand_fetch.sv
// Operand fetch stage: register-bank read, writeback bypass, scoreboard hazard
// detection and a single-entry output register toward execute.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_sr1,
  input  logic [4:0]  in_sr2,
  input  logic [4:0]  in_dr,
  input  logic        in_wen,
  input  logic [15:0] in_ctrl,
  output logic [4:0]  rf_sr1,
  output logic [4:0]  rf_sr2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_dr,
  output logic        out_wen,
  output logic [15:0] out_ctrl,
  output logic        err_idx,
  output logic [15:0] stall_cnt
);

  localparam logic [4:0] MaxIdx = 5'd17;

  logic [17:0] busy;
  logic [31:0] busyExt;
  logic        sr1Legal, sr2Legal, drLegal, wbLegal;
  logic        bypass1, bypass2, blocked1, blocked2, waw, hazard;
  logic        accept, badIdx;
  logic [31:0] op1Sel, op2Sel;
  logic [17:0] busyNext;

  assign rf_sr1 = in_sr1;
  assign rf_sr2 = in_sr2;

  // Widened copy lets out-of-range indices read as "not busy" without a bounds warning.
  assign busyExt  = {14'b0, busy};
  assign sr1Legal = (in_sr1 <= MaxIdx);
  assign sr2Legal = (in_sr2 <= MaxIdx);
  assign drLegal  = (in_dr <= MaxIdx);
  assign wbLegal  = (wb_dr <= MaxIdx);

  assign bypass1  = wb_valid && (wb_dr == in_sr1) && sr1Legal;
  assign bypass2  = wb_valid && (wb_dr == in_sr2) && sr2Legal;
  assign blocked1 = busyExt[in_sr1] && !bypass1;
  assign blocked2 = busyExt[in_sr2] && !bypass2;
  assign waw      = in_wen && busyExt[in_dr] && !(wb_valid && (wb_dr == in_dr));
  assign hazard   = blocked1 || blocked2 || waw;

  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign badIdx   = !sr1Legal || !sr2Legal || (in_wen && !drLegal);

  assign op1Sel = bypass1 ? wb_data : (sr1Legal ? rf_data1 : 32'h0);
  assign op2Sel = bypass2 ? wb_data : (sr2Legal ? rf_data2 : 32'h0);

  // Writeback clears first so that an acceptance on the same register wins.
  always_comb begin
    busyNext = busy;
    if (wb_valid && wbLegal)
      busyNext[wb_dr] = 1'b0;
    if (accept && in_wen && drLegal)
      busyNext[in_dr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= '0;
      err_idx   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      busy    <= busyNext;
      err_idx <= accept && badIdx;
      if (in_valid && !in_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_dr    <= '0;
      out_wen   <= 1'b0;
      out_ctrl  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= op1Sel;
      out_op2   <= op2Sel;
      out_dr    <= in_dr;
      out_wen   <= in_wen;
      out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register bank and
// hand-computed expected values.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_sr1, in_sr2, in_dr;
  logic        in_wen;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_sr1, rf_sr2;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_valid;
  logic [4:0]  wb_dr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_dr;
  logic        out_wen;
  logic [15:0] out_ctrl;
  logic        err_idx;
  logic [15:0] stall_cnt;

  logic [31:0] rf [0:31];
  int cmpCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  // Register bank: combinational read, written by writeback on the clock edge.
  assign rf_data1 = rf[rf_sr1];
  assign rf_data2 = rf[rf_sr2];
  always @(posedge clk)
    if (wb_valid && wb_dr <= 5'd17) rf[wb_dr] <= wb_data;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .in_wen(in_wen), .in_ctrl(in_ctrl),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_dr(out_dr), .out_wen(out_wen), .out_ctrl(out_ctrl),
    .err_idx(err_idx), .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [4:0] d,
                               input logic w, input logic [15:0] c);
    in_valid = v; in_sr1 = s1; in_sr2 = s2; in_dr = d; in_wen = w; in_ctrl = c;
  endtask

  task automatic applyWriteback(input logic v, input logic [4:0] d, input logic [31:0] data);
    wb_valid = v; wb_dr = d; wb_data = data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'h11; rf[3] = 32'h5; rf[4] = 32'h7;
    reset = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
    applyWriteback(1'b0, 5'd0, 32'h0);

    #12;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_err_idx", {31'b0, err_idx}, 32'd0);
    checkOutput("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    checkOutput("rst_out_op1", out_op1, 32'd0);
    checkOutput("rst_out_ctrl", {16'b0, out_ctrl}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b1;
    step();

    // Plain issue
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 16'hA5A5);
    #1 checkOutput("issue_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    applyStimulus(1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 16'h0);
    checkOutput("issue_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("issue_op1", out_op1, 32'd5);
    checkOutput("issue_op2", out_op2, 32'd7);
    checkOutput("issue_dr", {27'b0, out_dr}, 32'd5);
    checkOutput("issue_wen", {31'b0, out_wen}, 32'd1);
    checkOutput("issue_ctrl", {16'b0, out_ctrl}, 32'h0000A5A5);
    #1 checkOutput("issue_busy5", {31'b0, in_ready}, 32'd0);

    // RAW stall, then writeback bypass
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd9, 1'b0, 16'h0BAD);
    for (int i = 1; i <= 3; i++) begin
      #1 checkOutput("raw_in_ready", {31'b0, in_ready}, 32'd0);
      step();
      checkOutput("raw_stall_cnt", {16'b0, stall_cnt}, i);
    end
    applyWriteback(1'b1, 5'd5, 32'hDEAD);
    #1 checkOutput("bypass_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    applyWriteback(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 16'h0);
    checkOutput("bypass_op1", out_op1, 32'hDEAD);
    checkOutput("bypass_op2", out_op2, 32'h11);
    checkOutput("bypass_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    #1 checkOutput("bypass_busy5_clear", {31'b0, in_ready}, 32'd1);

    // Backpressure for 4 cycles, then back-to-back replacement
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd7, 1'b0, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      step();
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_op1_stable", out_op1, 32'hDEAD);
    end
    checkOutput("bp_stall_cnt", {16'b0, stall_cnt}, 32'd7);
    out_ready = 1'b1;
    #1 checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0);
    checkOutput("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("b2b_op1", out_op1, 32'd5);
    checkOutput("b2b_op2", out_op2, 32'd7);
    checkOutput("b2b_ctrl", {16'b0, out_ctrl}, 32'h00001234);
    checkOutput("b2b_dr", {27'b0, out_dr}, 32'd7);
    step();
    checkOutput("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // Set/clear collision on register 6
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 16'h0006);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 16'h0066);
    applyWriteback(1'b1, 5'd6, 32'h66);
    #1 checkOutput("coll_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    applyWriteback(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 5'd6, 5'd0, 5'd0, 1'b0, 16'h0);
    checkOutput("coll_ctrl", {16'b0, out_ctrl}, 32'h00000066);
    #1 checkOutput("coll_busy6_kept", {31'b0, in_ready}, 32'd0);

    // Illegal indices
    applyStimulus(1'b1, 5'd20, 5'd3, 5'd25, 1'b1, 16'h00EE);
    #1 checkOutput("ill_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    applyStimulus(1'b0, 5'd6, 5'd0, 5'd0, 1'b0, 16'h0);
    checkOutput("ill_op1", out_op1, 32'd0);
    checkOutput("ill_op2", out_op2, 32'd5);
    checkOutput("ill_err_idx", {31'b0, err_idx}, 32'd1);
    step();
    checkOutput("ill_err_idx_pulse", {31'b0, err_idx}, 32'd0);
    checkOutput("ill_busy6_kept", {31'b0, in_ready}, 32'd0);
    in_sr1 = 5'd5;
    #1 checkOutput("ill_busy5_free", {31'b0, in_ready}, 32'd1);

    // Asynchronous reset between edges
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 5'd6, 5'd0, 5'd0, 1'b0, 16'h0);
    out_ready = 1'b0;
    checkOutput("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("arst_busy_clear", {31'b0, in_ready}, 32'd1);
    checkOutput("arst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    checkOutput("arst_out_op1", out_op1, 32'd0);
    reset = 1'b1;
    step();
    checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
